// File: rtl/mac_operand_sequencer.sv
// Operand FIFO plus IDLE/RUN/FLUSH issue sequencer driving a registered-input 8x8 MAC accumulator.
// Define MAC_SEQ_ELEM_COUNT_EN to add the saturating result_count element counter output.
module mac_operand_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       aclr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_last,
    output logic [7:0] mac_dataa,
    output logic [7:0] mac_datab,
    output logic       mac_clken,
    output logic       mac_sload,
    output logic       result_valid,
    output logic       busy
`ifdef MAC_SEQ_ELEM_COUNT_EN
    ,
    output logic [7:0] result_count
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    logic [16:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, full;
    logic [7:0]    head_a, head_b;
    logic          head_last;

    state_e     state_q, state_d;
    logic [7:0] dataa_q, dataa_d, datab_q, datab_d;
    logic       clken_q, clken_d, sload_q, sload_d;
    logic       flush_slot_q, flush_slot_d;
    logic       result_valid_q;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (count_q != '0);
    assign {head_last, head_a, head_b} = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push && !aclr) begin
            mem_q[wr_ptr_q] <= {in_last, in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + (AW+1)'(1);
            else if (!push && pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q        <= IDLE;
            dataa_q        <= '0;
            datab_q        <= '0;
            clken_q        <= 1'b0;
            sload_q        <= 1'b0;
            flush_slot_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dataa_q        <= dataa_d;
            datab_q        <= datab_d;
            clken_q        <= clken_d;
            sload_q        <= sload_d;
            flush_slot_q   <= flush_slot_d;
            result_valid_q <= flush_slot_q;
        end
    end

    // FLUSH marks the last element's slot; the edge leaving it always issues
    // one more slot so the MAC's input register drains into the accumulator.
    always_comb begin
        state_d      = state_q;
        dataa_d      = dataa_q;
        datab_d      = datab_q;
        clken_d      = 1'b0;
        sload_d      = 1'b0;
        flush_slot_d = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (pop) begin
                    dataa_d = head_a;
                    datab_d = head_b;
                    clken_d = 1'b1;
                    sload_d = (state_q == IDLE);
                    state_d = head_last ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                clken_d      = 1'b1;
                flush_slot_d = 1'b1;
                if (pop) begin
                    dataa_d = head_a;
                    datab_d = head_b;
                    sload_d = 1'b1;
                    state_d = head_last ? FLUSH : RUN;
                end else begin
                    dataa_d = '0;
                    datab_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mac_dataa    = dataa_q;
    assign mac_datab    = datab_q;
    assign mac_clken    = clken_q;
    assign mac_sload    = sload_q;
    assign result_valid = result_valid_q;
    assign busy         = pop || (state_q != IDLE) || flush_slot_q;

`ifdef MAC_SEQ_ELEM_COUNT_EN
    logic [7:0] vec_cnt_q, pend_cnt_q, result_count_q;

    // The finished count is staged once so a back-to-back vector opening in
    // the flush slot cannot overwrite it before the result pulse.
    always_ff @(posedge clk) begin
        if (aclr) begin
            vec_cnt_q      <= '0;
            pend_cnt_q     <= '0;
            result_count_q <= '0;
        end else begin
            if (pop) begin
                if (state_q != RUN)          vec_cnt_q <= 8'd1;
                else if (vec_cnt_q != 8'hFF) vec_cnt_q <= vec_cnt_q + 8'd1;
            end
            if (state_q == FLUSH) pend_cnt_q     <= vec_cnt_q;
            if (flush_slot_q)     result_count_q <= pend_cnt_q;
        end
    end

    assign result_count = result_count_q;
`endif

endmodule
